// File: rtl/light_hash_pkg.sv
// light_hash_pkg
// Shared definitions for the light_hash_param byte-serial hash:
//   - IV8       : 8-byte initial value pattern (lanes beyond 8 XOR in i/8)
//   - state_t   : two-state control FSM encoding
//   - *_LO/*_HI : ASCII ranges treated as alphanumeric
//   - iv_byte   : initial value for state lane i
//   - is_alnum  : alphanumeric classifier for incoming bytes
package light_hash_pkg;

    localparam logic [0:7][7:0] IV8 = {
        8'h34, 8'h55, 8'h0F, 8'h14, 8'hDA, 8'hC0, 8'h2B, 8'hEE
    };

    typedef enum logic {
        IDLE,
        ROUND
    } state_t;

    localparam logic [7:0] DIGIT_LO = 8'h30;
    localparam logic [7:0] DIGIT_HI = 8'h39;
    localparam logic [7:0] UPPER_LO = 8'h41;
    localparam logic [7:0] UPPER_HI = 8'h5A;
    localparam logic [7:0] LOWER_LO = 8'h61;
    localparam logic [7:0] LOWER_HI = 8'h7A;

    function automatic logic [7:0] iv_byte(input int unsigned i);
        return IV8[3'(i % 8)] ^ 8'(i / 8);
    endfunction

    function automatic logic is_alnum(input logic [7:0] b);
        return ((b >= DIGIT_LO) && (b <= DIGIT_HI)) ||
               ((b >= UPPER_LO) && (b <= UPPER_HI)) ||
               ((b >= LOWER_LO) && (b <= LOWER_HI));
    endfunction

endpackage

// File: rtl/light_hash_param_aes_sbox.sv
// aes_sbox
// Combinational AES forward substitution box.
//   value : 8-bit input byte
//   subst : S-box image of value
module aes_sbox (
    input  logic [7:0] value,
    output logic [7:0] subst
);

    // Element 0 sits in the leftmost (most significant) byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign subst = SBOX[value];

endmodule

// File: rtl/light_hash_param.sv
// light_hash_param
// Byte-serial parameterised hash. Each accepted byte is mixed into an
// N-byte state over ROUNDS cycles; the byte flagged last produces the digest.
//   clk              : clock, rising edge
//   rst              : asynchronous active-high reset
//   msg_byte         : message byte
//   msg_valid        : msg_byte / msg_last valid
//   msg_last         : final byte of the message
//   msg_ready        : high while a byte can be accepted (IDLE)
//   digest           : completed hash, H[0] in the most significant byte
//   digest_valid     : digest holds a completed message hash
//   err_invalid_byte : one-cycle pulse after a rejected byte
module light_hash_param
    import light_hash_pkg::*;
#(
    parameter int DIGEST_BYTES = 8,
    parameter int ROUNDS       = 32,
    parameter int CHECK_ALNUM  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                msg_byte,
    input  logic                      msg_valid,
    input  logic                      msg_last,
    output logic                      msg_ready,
    output logic [8*DIGEST_BYTES-1:0] digest,
    output logic                      digest_valid,
    output logic                      err_invalid_byte
);

    localparam int N  = DIGEST_BYTES;
    localparam int RW = $clog2(ROUNDS + 1);

    state_t         state;
    logic [RW-1:0]  r;
    logic [7:0]     r8;
    logic [7:0]     m;
    logic           last;
    logic [8*N-1:0] h;
    logic [8*N-1:0] h_next;
    logic [8*N-1:0] iv;
    logic           bad;

    assign msg_ready = (state == IDLE);
    assign bad       = (CHECK_ALNUM != 0) && !is_alnum(msg_byte);

    always_comb begin
        r8         = '0;
        r8[RW-1:0] = r;
    end

    // Lane i lives at byte offset N-1-i so that H[0] is the top byte.
    for (genvar i = 0; i < N; i++) begin : g_lane
        localparam int HI = 8 * (N - 1 - i);
        localparam int NX = 8 * (N - 1 - ((i + 1) % N));
        logic [7:0] cur;
        logic [7:0] sub;

        assign cur = h[HI +: 8];
        assign iv[HI +: 8] = iv_byte(i);

        aes_sbox u_sbox (
            .value (h[NX +: 8] ^ m),
            .subst (sub)
        );

        assign h_next[HI +: 8] = sub ^ {cur[6:0], cur[7]} ^ r8;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            r                <= '0;
            m                <= '0;
            last             <= 1'b0;
            h                <= iv;
            digest           <= '0;
            digest_valid     <= 1'b0;
            err_invalid_byte <= 1'b0;
        end else begin
            err_invalid_byte <= 1'b0;
            case (state)
                IDLE: begin
                    if (msg_valid) begin
                        digest_valid <= 1'b0;
                        if (bad) begin
                            // Rejected byte: no rounds, but a last flag still closes the message.
                            err_invalid_byte <= 1'b1;
                            if (msg_last) begin
                                digest       <= h;
                                digest_valid <= 1'b1;
                                h            <= iv;
                            end
                        end else begin
                            m     <= msg_byte;
                            last  <= msg_last;
                            r     <= '0;
                            state <= ROUND;
                        end
                    end
                end
                ROUND: begin
                    h <= h_next;
                    if (r == RW'(ROUNDS - 1)) begin
                        state <= IDLE;
                        if (last) begin
                            digest       <= h_next;
                            digest_valid <= 1'b1;
                            h            <= iv;
                        end
                    end else begin
                        r <= r + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
